// File: rtl/blram_dp.sv
// blram_dp: dual-port block RAM with byte enables, read-during-write mode, output register and post-reset clear
module blram_dp #(
  parameter int    DATA_W         = 16,
  parameter int    ADDR_W         = 13,
  parameter int    DEPTH          = 8192,
  parameter int    RDW_MODE       = 0,
  parameter int    OUT_REG        = 0,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_a_en,
  input  logic                i_a_we,
  input  logic [DATA_W/8-1:0] i_a_be,
  input  logic [ADDR_W-1:0]   i_a_addr,
  input  logic [DATA_W-1:0]   i_a_data,
  output logic [DATA_W-1:0]   o_a_data,
  output logic                o_a_valid,
  input  logic                i_b_en,
  input  logic [ADDR_W-1:0]   i_b_addr,
  output logic [DATA_W-1:0]   o_b_data,
  output logic                o_b_valid,
  output logic                o_busy
);
  localparam int NB = DATA_W / 8;
  localparam int MW = $clog2(DEPTH);
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t            r_state;
  logic [MW-1:0]     r_cnt;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_a_v1, r_b_v1, r_a_v2, r_b_v2;
  logic [DATA_W-1:0] r_a_d1, r_b_d1, r_a_d2, r_b_d2;
  logic              w_ready, w_a_acc, w_b_acc, w_a_in, w_b_in;
  logic [MW-1:0]     w_a_idx, w_b_idx;
  logic [DATA_W-1:0] w_a_old, w_a_new, w_a_rd, w_b_rd;

  assign w_ready = rst && r_state == S_READY;
  assign w_a_acc = w_ready && i_a_en;
  assign w_b_acc = w_ready && i_b_en;
  assign w_a_in  = 32'(i_a_addr) < DEPTH;
  assign w_b_in  = 32'(i_b_addr) < DEPTH;
  assign w_a_idx = i_a_addr[MW-1:0];
  assign w_b_idx = i_b_addr[MW-1:0];
  assign w_a_old = w_a_in ? r_mem[w_a_idx] : '0;
  assign w_b_rd  = w_b_in ? r_mem[w_b_idx] : '0;
  assign w_a_rd  = (RDW_MODE != 0 && i_a_we && w_a_in) ? w_a_new : w_a_old;

  always_comb begin
    w_a_new = w_a_old;
    for (int k = 0; k < NB; k++)
      if (i_a_be[k]) w_a_new[8*k +: 8] = i_a_data[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)
      r_mem[r_cnt] <= '0;
    else if (w_a_acc && i_a_we && w_a_in)
      for (int k = 0; k < NB; k++)
        if (i_a_be[k]) r_mem[w_a_idx][8*k +: 8] <= i_a_data[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_READY;
      r_busy  <= CLEAR_ON_RESET != 0;
      r_cnt   <= '0;
      r_a_v1  <= 1'b0;
      r_b_v1  <= 1'b0;
      r_a_v2  <= 1'b0;
      r_b_v2  <= 1'b0;
      r_a_d1  <= '0;
      r_b_d1  <= '0;
      r_a_d2  <= '0;
      r_b_d2  <= '0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == MW'(DEPTH - 1)) begin
          r_state <= S_READY;
          r_busy  <= 1'b0;
        end
      end
      r_a_v1 <= w_a_acc;
      r_b_v1 <= w_b_acc;
      if (w_a_acc) r_a_d1 <= w_a_rd;
      if (w_b_acc) r_b_d1 <= w_b_rd;
      r_a_v2 <= r_a_v1;
      r_b_v2 <= r_b_v1;
      if (r_a_v1) r_a_d2 <= r_a_d1;
      if (r_b_v1) r_b_d2 <= r_b_d1;
    end
  end

  assign o_a_data  = OUT_REG != 0 ? r_a_d2 : r_a_d1;
  assign o_a_valid = OUT_REG != 0 ? r_a_v2 : r_a_v1;
  assign o_b_data  = OUT_REG != 0 ? r_b_d2 : r_b_d1;
  assign o_b_valid = OUT_REG != 0 ? r_b_v2 : r_b_v1;
  assign o_busy    = r_busy;
endmodule

// File: tb/tb_blram_dp.sv
// tb_blram_dp: three blram_dp configurations on shared stimulus, checked against
// a word-level memory model every cycle plus hand-computed expectations.
module tb_blram_dp;
  // instance 0: read-first, no out reg, DEPTH 6000; 1: write-first, out reg; 2: clear-on-reset, DEPTH 16
  function automatic int dep(int d);  return d == 0 ? 6000 : d == 1 ? 8192 : 16; endfunction
  function automatic int rdw(int d);  return d == 1 ? 1 : 0; endfunction
  function automatic int oreg(int d); return d == 1 ? 1 : 0; endfunction
  function automatic int clr(int d);  return d == 2 ? 1 : 0; endfunction

  logic clk = 0, rst = 1;
  logic a_en = 0, a_we = 0, b_en = 0;
  logic [1:0] a_be = 0;
  logic [12:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_data = 0;
  logic [2:0][15:0] oa_d, ob_d;
  logic [2:0] oa_v, ob_v, obusy;
  int checks = 0, errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    blram_dp #(.DATA_W(16), .ADDR_W(13), .DEPTH(dep(g)), .RDW_MODE(rdw(g)),
               .OUT_REG(oreg(g)), .CLEAR_ON_RESET(clr(g)), .INIT_FILE("")) u_dut (
      .clk(clk), .rst(rst),
      .i_a_en(a_en), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_data(a_data),
      .o_a_data(oa_d[g]), .o_a_valid(oa_v[g]),
      .i_b_en(b_en), .i_b_addr(b_addr), .o_b_data(ob_d[g]), .o_b_valid(ob_v[g]),
      .o_busy(obusy[g])
    );
  end

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endfunction

  bit [15:0] mem [3][8192];
  int mbusy [3] = '{0, 0, 0};
  logic [15:0] ea_d [3], eb_d [3], pa_d [3], pb_d [3];
  bit ea_v [3], eb_v [3], pa_v [3], pb_v [3];

  task automatic step(int d);
    bit ra_v = 0, rb_v = 0;
    logic [15:0] ra_d = 0, rb_d = 0, old, nw;
    bit ain = a_addr < dep(d), bin = b_addr < dep(d);
    if (mbusy[d] > 0) begin
      mbusy[d]--;
      if (mbusy[d] == 0) for (int i = 0; i < dep(d); i++) mem[d][i] = 0;
    end else begin
      old = ain ? mem[d][a_addr] : 16'h0;
      nw = {a_be[1] ? a_data[15:8] : old[15:8], a_be[0] ? a_data[7:0] : old[7:0]};
      if (b_en) begin rb_v = 1; rb_d = bin ? mem[d][b_addr] : 16'h0; end
      if (a_en) begin
        ra_v = 1;
        ra_d = (rdw(d) == 1 && a_we) ? (ain ? nw : 16'h0) : old;
        if (a_we && ain) mem[d][a_addr] = nw;
      end
    end
    if (oreg(d) == 1) begin
      ea_v[d] = pa_v[d]; if (pa_v[d]) ea_d[d] = pa_d[d];
      eb_v[d] = pb_v[d]; if (pb_v[d]) eb_d[d] = pb_d[d];
      pa_v[d] = ra_v; pa_d[d] = ra_d; pb_v[d] = rb_v; pb_d[d] = rb_d;
    end else begin
      ea_v[d] = ra_v; if (ra_v) ea_d[d] = ra_d;
      eb_v[d] = rb_v; if (rb_v) eb_d[d] = rb_d;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        mbusy[d] = clr(d) == 1 ? dep(d) : 0;
        ea_v[d] = 0; eb_v[d] = 0; pa_v[d] = 0; pb_v[d] = 0;
        ea_d[d] = 0; eb_d[d] = 0; pa_d[d] = 0; pb_d[d] = 0;
      end
    end else for (int d = 0; d < 3; d++) step(d);
  end

  initial forever begin
    @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("cmp%0d_busy", d), obusy[d], mbusy[d] > 0);
      chk($sformatf("cmp%0d_a_valid", d), oa_v[d], ea_v[d]);
      chk($sformatf("cmp%0d_a_data", d), oa_d[d], ea_d[d]);
      chk($sformatf("cmp%0d_b_valid", d), ob_v[d], eb_v[d]);
      chk($sformatf("cmp%0d_b_data", d), ob_d[d], eb_d[d]);
    end
  end

  task automatic go();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    a_en = 0; a_we = 0; b_en = 0;
  endtask
  task automatic wr(logic [12:0] ad, logic [15:0] dt, logic [1:0] be);
    a_en = 1; a_we = 1; a_addr = ad; a_data = dt; a_be = be;
    go(); idle();
  endtask
  task automatic rd(logic [12:0] ad);
    a_en = 1; a_we = 0; a_addr = ad;
    go(); idle();
  endtask

  initial begin
    #1 rst = 0;
    repeat (3) go();
    chk("rst_a_data", oa_d[0], 16'h0);
    chk("rst_a_valid", oa_v[0], 0);
    chk("rst_busy_clr", obusy[2], 1);
    chk("rst_busy_noclr", obusy[0], 0);
    rst = 1;
    wr(3, 16'h5A5A, 2'b11);
    repeat (14) go();
    chk("busy_edge15", obusy[2], 1);
    go();
    chk("busy_edge16", obusy[2], 0);
    rd(3);
    chk("rd3_d0", oa_d[0], 16'h5A5A);
    chk("rd3_d2_dropped", oa_d[2], 16'h0);
    chk("rd3_d2_valid", oa_v[2], 1);
    // latency
    wr(13'h10, 16'hBEEF, 2'b11);
    go(); go();
    rd(13'h10);
    chk("lat1_valid", oa_v[0], 1);
    chk("lat1_data", oa_d[0], 16'hBEEF);
    chk("lat2_early_valid", oa_v[1], 0);
    chk("oor_d2_data", oa_d[2], 16'h0);
    go();
    chk("lat2_valid", oa_v[1], 1);
    chk("lat2_data", oa_d[1], 16'hBEEF);
    chk("lat1_hold_valid", oa_v[0], 0);
    chk("lat1_hold_data", oa_d[0], 16'hBEEF);
    // byte enables
    wr(5, 16'h1234, 2'b11);
    wr(5, 16'hABCD, 2'b01);
    rd(5);
    chk("be01", oa_d[0], 16'h12CD);
    wr(5, 16'hABCD, 2'b00);
    rd(5);
    chk("be00", oa_d[0], 16'h12CD);
    // same-address collision
    wr(13'h20, 16'h1111, 2'b11);
    a_en = 1; a_we = 1; a_addr = 13'h20; a_data = 16'h2222; a_be = 2'b11;
    b_en = 1; b_addr = 13'h20;
    go(); idle();
    chk("col_rf_a", oa_d[0], 16'h1111);
    chk("col_rf_b", ob_d[0], 16'h1111);
    go();
    chk("col_wf_a", oa_d[1], 16'h2222);
    chk("col_wf_b", ob_d[1], 16'h1111);
    a_en = 1; a_addr = 13'h20; b_en = 1; b_addr = 13'h20;
    go(); idle();
    chk("col_after_a0", oa_d[0], 16'h2222);
    chk("col_after_b0", ob_d[0], 16'h2222);
    go();
    chk("col_after_a1", oa_d[1], 16'h2222);
    chk("col_after_b1", ob_d[1], 16'h2222);
    // out of range and streaming
    wr(6000, 16'h7777, 2'b11);
    rd(6000);
    chk("oor_valid", oa_v[0], 1);
    chk("oor_data", oa_d[0], 16'h0);
    go();
    chk("inrange6000_d1", oa_d[1], 16'h7777);
    for (int i = 0; i < 16; i++) wr(13'(i), 16'h0100 + 16'(i), 2'b11);
    for (int i = 0; i < 8; i++) begin
      b_en = 1; b_addr = 13'(i);
      go();
      chk($sformatf("stream_v%0d", i), ob_v[0], 1);
      chk($sformatf("stream_d%0d", i), ob_d[0], 16'h0100 + 16'(i));
    end
    idle(); go();
    chk("stream_end_v", ob_v[0], 0);
    // reset, restart mid-clear, writes dropped while busy
    rst = 0;
    go(); go();
    chk("rst2_busy", obusy[2], 1);
    chk("rst2_a_data", oa_d[0], 16'h0);
    rst = 1;
    repeat (7) go();
    chk("midclear_busy", obusy[2], 1);
    rst = 0;
    go();
    rst = 1;
    wr(2, 16'h5555, 2'b11);
    chk("busy_no_valid", oa_v[2], 0);
    chk("ready_valid", oa_v[0], 1);
    repeat (14) go();
    chk("restart_edge15", obusy[2], 1);
    go();
    chk("restart_edge16", obusy[2], 0);
    for (int i = 0; i < 16; i++) begin
      a_en = 1; a_we = 0; a_addr = 13'(i); b_en = 1; b_addr = 13'(15 - i);
      go();
      chk($sformatf("clr_a%0d", i), oa_d[2], 16'h0);
      chk($sformatf("clr_b%0d", i), ob_d[2], 16'h0);
    end
    idle();
    rd(7);
    chk("survive_rst", oa_d[0], 16'h0107);
    go();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
